// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Runs one RV32I load or store against a single-port, word-wide data memory
//   with a ready handshake. It steers byte lanes, generates write strobes,
//   sign- or zero-extends load results, rejects misaligned accesses and
//   illegal funct3 codes, and aborts a request that waits longer than TIMEOUT
//   cycles. The pipeline is stalled while a request is outstanding.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | no request outstanding; a valid start issues the memory request
//   WAIT  | request on the bus, waiting for mem_ready or the timeout limit
//   RESP  | one unstalled cycle so the pipeline advances; inputs are ignored
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   mem_read_control    load requested (wins if asserted with a store)
//   mem_write_control   store requested
//   funct3              access size / sign field
//   addr                byte address from the ALU
//   store_data          rs2 value
//   stall               hold the pipeline
//   load_data           extended load result, held until the next load
//   load_valid          one-cycle pulse when load_data updates
//   access_fault        one-cycle pulse: misaligned, illegal funct3, timeout
//   mem_req/mem_we/mem_addr/mem_wstrb/mem_wdata   registered memory request
//   mem_rdata, mem_ready                          memory response
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read_control,
    input  logic                  mem_write_control,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           store_data,
    output logic                  stall,
    output logic [31:0]           load_data,
    output logic                  load_valid,
    output logic                  access_fault,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_wstrb,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter only needs to reach TIMEOUT-1; the abort happens on the edge
    // that would make it TIMEOUT.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT =
        (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] timeout_cnt;
    logic             timeout_hit;

    logic             is_load;
    logic             is_store;
    logic             start_req;
    logic             f3_legal;
    logic             misaligned;
    logic             start_ok;
    logic             start_bad;

    logic             do_start;
    logic             do_bad;
    logic             do_done;
    logic             do_abort;

    logic [3:0]       wstrb_calc;
    logic [31:0]      wdata_calc;

    logic [2:0]       lat_f3;
    logic [1:0]       lat_off;
    logic             lat_load;
    logic [7:0]       byte_lane;
    logic [15:0]      half_lane;
    logic [31:0]      load_ext;

    // ------------------------------------------------------------------
    // Start decode: a simultaneous load and store is treated as a load.
    // ------------------------------------------------------------------
    assign is_load   = mem_read_control;
    assign is_store  = mem_write_control & ~mem_read_control;
    assign start_req = mem_read_control | mem_write_control;

    always_comb begin
        f3_legal = 1'b0;
        if (is_load) begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
                default:                                f3_legal = 1'b0;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
                default:                f3_legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    assign start_ok  = start_req & f3_legal & ~misaligned;
    assign start_bad = start_req & ~(f3_legal & ~misaligned);

    assign timeout_hit = (TIMEOUT != 0) && (timeout_cnt == CNT_LIMIT);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        do_start   = 1'b0;
        do_bad     = 1'b0;
        do_done    = 1'b0;
        do_abort   = 1'b0;
        case (state)
            IDLE: begin
                stall    = start_ok;
                do_start = start_ok;
                do_bad   = start_bad;
                if (start_ok) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                // mem_ready takes priority over a coincident timeout.
                if (mem_ready) begin
                    do_done    = 1'b1;
                    state_next = RESP;
                end else if (timeout_hit) begin
                    do_abort   = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Store lane steering
    // ------------------------------------------------------------------
    always_comb begin
        wstrb_calc = 4'b0000;
        wdata_calc = store_data;
        case (funct3[1:0])
            2'b00: begin
                wstrb_calc = 4'b0001 << addr[1:0];
                wdata_calc = {4{store_data[7:0]}};
            end
            2'b01: begin
                wstrb_calc = addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{store_data[15:0]}};
            end
            default: begin
                wstrb_calc = 4'b1111;
                wdata_calc = store_data;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load lane extraction, using the size and offset latched at start
    // ------------------------------------------------------------------
    always_comb begin
        byte_lane = mem_rdata[7:0];
        case (lat_off)
            2'd0:    byte_lane = mem_rdata[7:0];
            2'd1:    byte_lane = mem_rdata[15:8];
            2'd2:    byte_lane = mem_rdata[23:16];
            default: byte_lane = mem_rdata[31:24];
        endcase
    end

    assign half_lane = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_ext = mem_rdata;
        case (lat_f3)
            3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane};
            3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
            3'b100:  load_ext = {24'd0, byte_lane};
            3'b101:  load_ext = {16'd0, half_lane};
            default: load_ext = mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Timeout counter: counts WAIT cycles without mem_ready
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_cnt <= '0;
        end else if (state != WAIT || do_done || do_abort) begin
            timeout_cnt <= '0;
        end else if (TIMEOUT != 0) begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Request and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wstrb    <= 4'b0000;
            mem_wdata    <= 32'd0;
            load_data    <= 32'd0;
            load_valid   <= 1'b0;
            access_fault <= 1'b0;
            lat_f3       <= 3'b000;
            lat_off      <= 2'b00;
            lat_load     <= 1'b0;
        end else begin
            load_valid   <= 1'b0;
            access_fault <= 1'b0;

            if (do_start) begin
                mem_req   <= 1'b1;
                mem_we    <= is_store;
                mem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                mem_wstrb <= is_store ? wstrb_calc : 4'b0000;
                mem_wdata <= is_store ? wdata_calc : 32'd0;
                lat_f3    <= funct3;
                lat_off   <= addr[1:0];
                lat_load  <= is_load;
            end

            if (do_bad) begin
                access_fault <= 1'b1;
            end

            if (do_done) begin
                mem_req <= 1'b0;
                if (lat_load) begin
                    load_data  <= load_ext;
                    load_valid <= 1'b1;
                end
            end

            if (do_abort) begin
                mem_req      <= 1'b0;
                access_fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Directed bench for load_store_unit with TIMEOUT=4. Each transaction is
//   driven by the txn task, which records what the DUT did over a fixed
//   window; the main sequence compares those records with hand-computed
//   values.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read_control;
    logic        mem_write_control;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        access_fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-transaction observations
    logic [31:0] c_addr;
    logic        c_we;
    logic [3:0]  c_wstrb;
    logic [31:0] c_wdata;
    int          n_stall;
    int          n_req;
    int          n_rise;
    int          n_valid;
    int          n_fault;
    logic        stall_at_valid;
    logic        stall_at_fault;

    always #5 clk = ~clk;

    load_store_unit #(
        .ADDR_WIDTH(32),
        .TIMEOUT   (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mem_read_control (mem_read_control),
        .mem_write_control(mem_write_control),
        .funct3           (funct3),
        .addr             (addr),
        .store_data       (store_data),
        .stall            (stall),
        .load_data        (load_data),
        .load_valid       (load_valid),
        .access_fault     (access_fault),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wstrb        (mem_wstrb),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_ready        (mem_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drives one access for a single cycle (or, with hold, until the RESP
    // cycle has been seen) and watches a fixed 10-cycle window. mem_ready is
    // raised only in WAIT cycle number ready_at (0 = never).
    task automatic txn(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rw, input int ready_at, input bit hold);
        int   widx;
        logic prev_req;
        bit   drop;
        c_addr = '0; c_we = 1'b0; c_wstrb = '0; c_wdata = '0;
        n_stall = 0; n_req = 0; n_rise = 0; n_valid = 0; n_fault = 0;
        stall_at_valid = 1'b1;
        stall_at_fault = 1'b1;
        @(posedge clk); #1;
        mem_read_control  = rd;
        mem_write_control = wr;
        funct3            = f3;
        addr              = a;
        store_data        = sd;
        mem_rdata         = rw;
        mem_ready         = 1'b0;
        widx     = 0;
        prev_req = mem_req;
        drop     = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (stall) n_stall++;
            if (mem_req) begin
                n_req++;
                c_addr  = mem_addr;
                c_we    = mem_we;
                c_wstrb = mem_wstrb;
                c_wdata = mem_wdata;
                if (!prev_req) n_rise++;
            end
            prev_req = mem_req;
            if (load_valid) begin
                n_valid++;
                stall_at_valid = stall;
            end
            if (access_fault) begin
                n_fault++;
                stall_at_fault = stall;
            end
            if (hold && n_req > 0 && !stall) drop = 1'b1;
            @(posedge clk); #1;
            if (!hold || drop) begin
                mem_read_control  = 1'b0;
                mem_write_control = 1'b0;
            end
            if (mem_req) begin
                widx++;
                mem_ready = (widx == ready_at);
            end else begin
                mem_ready = 1'b0;
            end
        end
        mem_read_control  = 1'b0;
        mem_write_control = 1'b0;
        mem_ready         = 1'b0;
    endtask

    initial begin
        rst_n             = 1'b0;
        mem_read_control  = 1'b0;
        mem_write_control = 1'b0;
        funct3            = 3'b000;
        addr              = 32'd0;
        store_data        = 32'd0;
        mem_rdata         = 32'd0;
        mem_ready         = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req",   {31'd0, mem_req},      32'd0);
        chk("rst_stall",     {31'd0, stall},        32'd0);
        chk("rst_load_data", load_data,             32'd0);
        chk("rst_fault",     {31'd0, access_fault}, 32'd0);
        chk("rst_mem_addr",  mem_addr,              32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset asserted while waiting on an LW
        @(posedge clk); #1;
        mem_read_control = 1'b1;
        funct3           = 3'b010;
        addr             = 32'h200;
        @(negedge clk);
        chk("mid_start_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        mem_read_control = 1'b0;
        @(negedge clk);
        chk("mid_wait1_req",  {31'd0, mem_req}, 32'd1);
        chk("mid_wait1_addr", mem_addr,         32'h200);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_wait2_req",  {31'd0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req",   {31'd0, mem_req}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall},   32'd0);
        chk("mid_rst_addr",  mem_addr,         32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_post_req",   {31'd0, mem_req}, 32'd0);
        chk("mid_post_stall", {31'd0, stall},   32'd0);

        // LB 0x103, zero wait states
        txn(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 32'h80112233, 1, 1'b0);
        chk("lb_addr",        c_addr,                   32'h100);
        chk("lb_wstrb",       {28'd0, c_wstrb},         32'h0);
        chk("lb_we",          {31'd0, c_we},            32'd0);
        chk("lb_data",        load_data,                32'hFFFFFF80);
        chk("lb_valid_cnt",   n_valid,                  32'd1);
        chk("lb_valid_stall", {31'd0, stall_at_valid},  32'd0);
        chk("lb_stall_cnt",   n_stall,                  32'd2);
        chk("lb_req_cnt",     n_req,                    32'd1);

        // LBU same stimulus
        txn(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 32'h80112233, 1, 1'b0);
        chk("lbu_data",       load_data,                32'h00000080);
        chk("lbu_stall_cnt",  n_stall,                  32'd2);

        // SH 0x0E
        txn(1'b0, 1'b1, 3'b001, 32'h0E, 32'hDEADBEEF, 32'h0, 1, 1'b0);
        chk("sh_we",          {31'd0, c_we},            32'd1);
        chk("sh_addr",        c_addr,                   32'h0C);
        chk("sh_wstrb",       {28'd0, c_wstrb},         32'hC);
        chk("sh_wdata",       c_wdata,                  32'hBEEFBEEF);
        chk("sh_load_hold",   load_data,                32'h00000080);
        chk("sh_valid_cnt",   n_valid,                  32'd0);

        // SB 0x01
        txn(1'b0, 1'b1, 3'b000, 32'h01, 32'h000000A5, 32'h0, 1, 1'b0);
        chk("sb_wstrb",       {28'd0, c_wstrb},         32'h2);
        chk("sb_wdata",       c_wdata,                  32'hA5A5A5A5);
        chk("sb_addr",        c_addr,                   32'h0);

        // LH 0x02 (upper half, negative), LHU 0x00 (lower half)
        txn(1'b1, 1'b0, 3'b001, 32'h02, 32'd0, 32'h80011234, 1, 1'b0);
        chk("lh_data",        load_data,                32'hFFFF8001);
        txn(1'b1, 1'b0, 3'b101, 32'h00, 32'd0, 32'h80011234, 1, 1'b0);
        chk("lhu_data",       load_data,                32'h00001234);

        // LW 0x44 with one wait state
        txn(1'b1, 1'b0, 3'b010, 32'h44, 32'd0, 32'h12345678, 2, 1'b0);
        chk("lw_data",        load_data,                32'h12345678);
        chk("lw_stall_cnt",   n_stall,                  32'd3);
        chk("lw_req_cnt",     n_req,                    32'd2);

        // Faulty starts
        txn(1'b1, 1'b0, 3'b010, 32'h102, 32'd0, 32'h0, 1, 1'b0);
        chk("mis_lw_fault",   n_fault,                  32'd1);
        chk("mis_lw_req",     n_req,                    32'd0);
        chk("mis_lw_stall",   n_stall,                  32'd0);
        txn(1'b1, 1'b0, 3'b011, 32'h100, 32'd0, 32'h0, 1, 1'b0);
        chk("ill_f3_fault",   n_fault,                  32'd1);
        chk("ill_f3_req",     n_req,                    32'd0);
        chk("ill_f3_stall",   n_stall,                  32'd0);
        txn(1'b0, 1'b1, 3'b001, 32'h0F, 32'h1, 32'h0, 1, 1'b0);
        chk("mis_sh_fault",   n_fault,                  32'd1);
        chk("mis_sh_req",     n_req,                    32'd0);
        chk("fault_load_hold", load_data,               32'h12345678);

        // SW timeout
        txn(1'b0, 1'b1, 3'b010, 32'h30, 32'h11223344, 32'h0, 0, 1'b0);
        chk("to_req_cnt",     n_req,                    32'd4);
        chk("to_fault_cnt",   n_fault,                  32'd1);
        chk("to_fault_stall", {31'd0, stall_at_fault},  32'd0);
        chk("to_stall_cnt",   n_stall,                  32'd5);
        chk("to_wstrb",       {28'd0, c_wstrb},         32'hF);
        chk("to_wdata",       c_wdata,                  32'h11223344);
        chk("to_load_hold",   load_data,                32'h12345678);

        // SW with mem_ready on the limit cycle
        txn(1'b0, 1'b1, 3'b010, 32'h30, 32'h11223344, 32'h0, 4, 1'b0);
        chk("lim_req_cnt",    n_req,                    32'd4);
        chk("lim_fault_cnt",  n_fault,                  32'd0);
        chk("lim_stall_cnt",  n_stall,                  32'd5);

        // Load and store together, held through RESP
        txn(1'b1, 1'b1, 3'b010, 32'h40, 32'h55555555, 32'hCAFEF00D, 1, 1'b1);
        chk("both_rises",     n_rise,                   32'd1);
        chk("both_req_cnt",   n_req,                    32'd1);
        chk("both_we",        {31'd0, c_we},            32'd0);
        chk("both_wstrb",     {28'd0, c_wstrb},         32'h0);
        chk("both_data",      load_data,                32'hCAFEF00D);
        chk("both_valid_cnt", n_valid,                  32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Executes the memory transaction requested by the decoder's mem_read_control / mem_write_control for RV32I loads and stores.
- Sits between the execute stage (address from the ALU, store data from rs2) and a single-port word-wide data memory with a ready handshake.
- Performs byte-lane steering, write strobes, load sign/zero extension, alignment and funct3 checking, and a bounded-wait timeout.
- Stalls the pipeline while a transaction is outstanding.

Parameters:
- ADDR_WIDTH, 32, byte-address width of addr and mem_addr.
- TIMEOUT, 16, maximum cycles to wait for mem_ready after mem_req rises before aborting; 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- mem_read_control  input  1  load requested this cycle
- mem_write_control  input  1  store requested this cycle
- funct3  input  3  access size/sign field of the instruction
- addr  input  ADDR_WIDTH  byte address (ALU result)
- store_data  input  32  rs2 value
- stall  output  1  hold the pipeline
- load_data  output  32  extended load result, held until the next load completes
- load_valid  output  1  one-cycle pulse: load_data updated
- access_fault  output  1  one-cycle pulse: misaligned address, illegal funct3, or timeout
- mem_req  output  1  memory request, registered
- mem_we  output  1  1 = write, registered
- mem_addr  output  ADDR_WIDTH  word-aligned address (addr[1:0] forced to 0), registered
- mem_wstrb  output  4  byte write strobes, registered; 0 on reads
- mem_wdata  output  32  lane-replicated store data, registered
- mem_rdata  input  32  read word, valid when mem_ready=1
- mem_ready  input  1  memory completes the request this cycle

Behaviour:
- Reset (async, rst_n=0): state IDLE; all registered outputs and the timeout counter 0; stall=0. Asserting reset mid-transaction drops mem_req immediately.
- start = (mem_read_control | mem_write_control) in IDLE. If both are high, the access is treated as a load and the store is suppressed.
- Legal funct3:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
  - stores: 000 SB, 001 SH, 010 SW
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- Faulty start (illegal funct3 or misaligned): no memory request; access_fault pulses on the next cycle; state stays IDLE; stall never asserted.
- States:
  - IDLE: stall = valid start (combinational). On a valid start, latch funct3 and addr[1:0]; set mem_req=1, mem_we, mem_addr, mem_wstrb, mem_wdata; go to WAIT.
  - WAIT: stall=1. mem_req and all request fields stay stable until mem_ready=1 is sampled. On that edge:
    - mem_req<=0.
    - Load: load_data<=extended lane, load_valid<=1.
    - Go to RESP.
  - WAIT timeout: the counter increments each WAIT cycle without mem_ready. When it reaches TIMEOUT: mem_req<=0, access_fault<=1, go to RESP. If mem_ready arrives on the same cycle as the limit, mem_ready wins.
  - RESP: stall=0 for exactly one cycle so the pipeline advances. Request inputs are ignored, so a still-held control signal cannot re-trigger. Next state IDLE.
- Latency: a memory with zero wait states (mem_ready high in the first WAIT cycle) gives stall for 2 cycles (IDLE-start cycle and WAIT); load_valid coincides with RESP.
- Store strobes and data:
  - SB: wstrb = 0001 << addr[1:0]; wdata = {4{store_data[7:0]}}.
  - SH: wstrb = 0011 << (2*addr[1]); wdata = {2{store_data[15:0]}}.
  - SW: wstrb = 1111; wdata = store_data.
- Load extraction:
  - Byte lane = mem_rdata[8*addr[1:0] +: 8].
  - Halfword lane = mem_rdata[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
- load_data is never modified by stores or faults.

Test Plan:
- Reset mid-WAIT: start LW, hold mem_ready=0 2 cycles, pulse rst_n low -> mem_req falls asynchronously; all outputs 0; state IDLE; stall=0.
- LB at addr 0x103, mem_rdata=0x80_11_22_33, mem_ready in first WAIT cycle -> mem_addr=0x100, wstrb=0000, load_data=0xFFFFFF80, load_valid one cycle in RESP, stall high exactly 2 cycles. LBU same stimulus -> load_data=0x00000080.
- SH at addr 0x0E, store_data=0xDEADBEEF -> mem_we=1, mem_addr=0x0C, wstrb=1100, wdata=0xBEEFBEEF; load_data unchanged.
- LW at 0x102 -> access_fault pulse, mem_req never rises, stall stays 0. Load with funct3=011 at aligned address -> same response.
- TIMEOUT=4, SW with mem_ready held 0 -> mem_req high 4 cycles then drops, access_fault pulses, one RESP cycle with stall=0. Repeat with mem_ready=1 on the 4th cycle -> no fault, normal completion.
- mem_read_control and mem_write_control both high and held through RESP, LW at 0x40 -> exactly one read transaction (mem_we=0, wstrb=0000), no second request issued from RESP.
